// File: rtl/tcb_sub_mem_if.sv
// TCB bus: handshake and request driven by the manager, response returned by the subordinate.
interface tcb_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32,
  parameter int unsigned BW = DW/8
) ();
  // ndn: 0 = little endian, 1 = big endian
  typedef struct packed {
    logic          cmd;
    logic          wen;
    logic          ndn;
    logic [AW-1:0] adr;
    logic [BW-1:0] ben;
    logic [DW-1:0] wdt;
  } req_t;

  typedef struct packed {
    logic err;
  } sts_t;

  typedef struct packed {
    logic [DW-1:0] rdt;
    sts_t          sts;
  } rsp_t;

  logic vld;
  logic rdy;
  req_t req;
  rsp_t rsp;

  modport man (output vld, output req, input rdy, input rsp);
  modport sub (input vld, input req, output rdy, output rsp);
endinterface

// File: rtl/tcb_sub_mem.sv
// Memory-backed TCB subordinate: byte-enabled writes, registered reads delayed by DLY stages,
// optional wait states on rdy, per-transfer endianness and out-of-range error reporting.
module tcb_sub_mem #(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned BW      = DW/8,
  parameter int unsigned SIZ     = 4096,
  parameter int unsigned DLY     = 1,
  parameter int unsigned WAIT    = 0,
  parameter bit          ERR_ENA = 1'b1
) (
  input logic clk,
  input logic rst,
  tcb_if.sub  tcb
);
  localparam int unsigned MAW   = $clog2(SIZ);
  localparam int unsigned LBW   = $clog2(BW);
  localparam int unsigned WORDS = SIZ / BW;

  logic                 trn;
  logic                 oor;
  logic                 wr;
  logic [MAW-LBW-1:0]   idx;
  logic [BW-1:0]        ben_m;
  logic [DW-1:0]        wdt_m;
  logic [DW-1:0]        rdt_m;
  logic [DW-1:0]        word;
  logic [DW-1:0]        mem [WORDS];

  assign trn  = tcb.vld & tcb.rdy;
  assign idx  = tcb.req.adr[MAW-1:LBW];
  assign oor  = ERR_ENA && ((tcb.req.adr >> MAW) != '0);
  assign wr   = trn & tcb.req.wen & ~oor & ~rst;
  assign word = mem[idx];

  // Bus lanes are mirrored onto memory bytes for big-endian transfers.
  always_comb begin
    ben_m = '0;
    wdt_m = '0;
    rdt_m = '0;
    for (int i = 0; i < BW; i++) begin
      if (tcb.req.ndn) begin
        ben_m[BW-1-i]          = tcb.req.ben[i];
        wdt_m[8*(BW-1-i) +: 8] = tcb.req.wdt[8*i +: 8];
        rdt_m[8*i +: 8]        = word[8*(BW-1-i) +: 8];
      end else begin
        ben_m[i]        = tcb.req.ben[i];
        wdt_m[8*i +: 8] = tcb.req.wdt[8*i +: 8];
        rdt_m[8*i +: 8] = word[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int b = 0; b < BW; b++) begin
      if (wr && ben_m[b]) begin
        mem[idx][8*b +: 8] <= wdt_m[8*b +: 8];
      end
    end
  end

  logic [DW-1:0]  st_rdt [DLY];
  logic           st_err [DLY];
  logic [DLY-1:0] st_vld;

  // Each stage only advances when it receives a fresh response, so the outputs hold between transfers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_vld <= '0;
      for (int i = 0; i < DLY; i++) begin
        st_rdt[i] <= '0;
        st_err[i] <= 1'b0;
      end
    end else begin
      st_vld[0] <= trn;
      if (trn) begin
        st_rdt[0] <= (tcb.req.wen || oor) ? '0 : rdt_m;
        st_err[0] <= oor;
      end
      for (int i = 1; i < DLY; i++) begin
        st_vld[i] <= st_vld[i-1];
        if (st_vld[i-1]) begin
          st_rdt[i] <= st_rdt[i-1];
          st_err[i] <= st_err[i-1];
        end
      end
    end
  end

  assign tcb.rsp = {st_rdt[DLY-1], st_err[DLY-1]};

  generate
    if (WAIT == 0) begin : g_nowait
      assign tcb.rdy = 1'b1;
    end else begin : g_wait
      typedef enum logic [1:0] {IDLE, WAITS, READY} state_t;
      state_t     state;
      state_t     state_n;
      logic [2:0] cnt;
      logic [2:0] cnt_n;
      logic       rdy_c;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          state <= IDLE;
          cnt   <= '0;
        end else begin
          state <= state_n;
          cnt   <= cnt_n;
        end
      end

      // READY is entered as the count reaches WAIT, giving exactly WAIT cycles of vld before rdy.
      always_comb begin
        state_n = state;
        cnt_n   = cnt;
        rdy_c   = 1'b0;
        case (state)
          IDLE: begin
            if (tcb.vld) begin
              cnt_n   = 3'd1;
              state_n = (WAIT == 1) ? READY : WAITS;
            end
          end
          WAITS: begin
            if (!tcb.vld) begin
              cnt_n   = '0;
              state_n = IDLE;
            end else begin
              cnt_n = cnt + 3'd1;
              if (cnt_n == 3'(WAIT)) begin
                state_n = READY;
              end
            end
          end
          READY: begin
            rdy_c = 1'b1;
            if (tcb.vld) begin
              cnt_n   = '0;
              state_n = IDLE;
            end
          end
          default: state_n = IDLE;
        endcase
      end

      assign tcb.rdy = rdy_c;
    end
  endgenerate

  logic unused_ok;
  assign unused_ok = ^{st_vld[DLY-1], tcb.req.cmd, tcb.req.adr};

endmodule

// File: tb/tb_tcb_sub_mem.sv
// Scoreboard bench for tcb_sub_mem: three configurations driven with directed and random transfers,
// expected responses come from a byte-array memory model and are checked when they are due.
module tb_tcb_sub_mem;
  localparam int ND  = 3;
  localparam int SIZ = 4096;

  // dut0: WAIT=0 DLY=1 ERR_ENA=1, dut1: WAIT=3 DLY=3 ERR_ENA=1, dut2: WAIT=0 DLY=3 ERR_ENA=0
  function automatic int wait_of(input int d);
    return (d == 1) ? 3 : 0;
  endfunction
  function automatic int dly_of(input int d);
    return (d == 0) ? 1 : 3;
  endfunction
  function automatic bit err_of(input int d);
    return (d != 2);
  endfunction

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  tcb_if #(.AW(32), .DW(32)) if0 ();
  tcb_if #(.AW(32), .DW(32)) if1 ();
  tcb_if #(.AW(32), .DW(32)) if2 ();

  tcb_sub_mem #(.AW(32), .DW(32), .BW(4), .SIZ(SIZ), .DLY(1), .WAIT(0), .ERR_ENA(1'b1))
    u0 (.clk(clk), .rst(rst), .tcb(if0));
  tcb_sub_mem #(.AW(32), .DW(32), .BW(4), .SIZ(SIZ), .DLY(3), .WAIT(3), .ERR_ENA(1'b1))
    u1 (.clk(clk), .rst(rst), .tcb(if1));
  tcb_sub_mem #(.AW(32), .DW(32), .BW(4), .SIZ(SIZ), .DLY(3), .WAIT(0), .ERR_ENA(1'b0))
    u2 (.clk(clk), .rst(rst), .tcb(if2));

  logic        rdy_a [ND];
  logic [31:0] rdt_a [ND];
  logic        err_a [ND];

  always_comb begin
    rdy_a[0] = if0.rdy;  rdt_a[0] = if0.rsp.rdt;  err_a[0] = if0.rsp.sts.err;
    rdy_a[1] = if1.rdy;  rdt_a[1] = if1.rsp.rdt;  err_a[1] = if1.rsp.sts.err;
    rdy_a[2] = if2.rdy;  rdt_a[2] = if2.rsp.rdt;  err_a[2] = if2.rsp.sts.err;
  end

  typedef struct {
    int          d;
    int          due;
    logic [31:0] rdt;
    logic        err;
    logic [31:0] mask;
  } exp_t;

  exp_t        sbq [$];
  logic [7:0]  mm [ND][SIZ];
  bit          kn [ND][SIZ];
  logic [31:0] held_rdt  [ND];
  logic        held_err  [ND];
  logic [31:0] held_mask [ND];

  task automatic checkOutput(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s dut%0d got %h want %h (cycle %0d)", name, d, act, exp, cyc);
    end
  endtask

  task automatic set_req(input int d, input logic v, input logic wen, input logic ndn,
                         input logic [31:0] adr, input logic [3:0] ben, input logic [31:0] wdt);
    case (d)
      0: begin
        if0.vld = v; if0.req.cmd = 1'b0; if0.req.wen = wen; if0.req.ndn = ndn;
        if0.req.adr = adr; if0.req.ben = ben; if0.req.wdt = wdt;
      end
      1: begin
        if1.vld = v; if1.req.cmd = 1'b0; if1.req.wen = wen; if1.req.ndn = ndn;
        if1.req.adr = adr; if1.req.ben = ben; if1.req.wdt = wdt;
      end
      default: begin
        if2.vld = v; if2.req.cmd = 1'b0; if2.req.wen = wen; if2.req.ndn = ndn;
        if2.req.adr = adr; if2.req.ben = ben; if2.req.wdt = wdt;
      end
    endcase
  endtask

  // Called at a negedge; returns at the negedge after the transfer edge with vld still high.
  task automatic applyStimulus(input int d, input logic wen, input logic ndn,
                               input logic [31:0] adr, input logic [3:0] ben, input logic [31:0] wdt);
    int   waits;
    int   base;
    int   b;
    bit   oor;
    exp_t e;
    waits = 0;
    set_req(d, 1'b1, wen, ndn, adr, ben, wdt);
    while (!rdy_a[d] && waits < 20) begin
      @(negedge clk);
      waits++;
    end
    checkOutput("wait", d, 32'(waits), 32'(wait_of(d)));
    if (!rdy_a[d]) begin
      set_req(d, 1'b0, 1'b0, 1'b0, '0, '0, '0);
      return;
    end
    oor    = err_of(d) && (adr >= 32'(SIZ));
    base   = int'(adr % 32'(SIZ)) & ~3;
    e.d    = d;
    e.due  = cyc + dly_of(d);
    e.err  = oor;
    e.rdt  = '0;
    e.mask = '1;
    if (!oor) begin
      for (int i = 0; i < 4; i++) begin
        b = ndn ? 3 - i : i;
        if (wen) begin
          if (ben[i]) begin
            mm[d][base+b] = wdt[8*i +: 8];
            kn[d][base+b] = 1'b1;
          end
        end else begin
          e.rdt[8*i +: 8]  = mm[d][base+b];
          e.mask[8*i +: 8] = kn[d][base+b] ? 8'hFF : 8'h00;
        end
      end
    end
    sbq.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle(input int d, input int n);
    set_req(d, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: due responses are compared, otherwise every output must hold its last response.
  always @(negedge clk) begin
    bit   upd [ND];
    exp_t e;
    for (int d = 0; d < ND; d++) upd[d] = 1'b0;
    while (sbq.size() > 0 && sbq[0].due == cyc) begin
      e = sbq.pop_front();
      checkOutput("rsp_rdt", e.d, rdt_a[e.d] & e.mask, e.rdt & e.mask);
      checkOutput("rsp_err", e.d, 32'(err_a[e.d]), 32'(e.err));
      held_rdt[e.d]  = e.rdt;
      held_err[e.d]  = e.err;
      held_mask[e.d] = e.mask;
      upd[e.d]       = 1'b1;
    end
    for (int d = 0; d < ND; d++) begin
      if (!upd[d]) begin
        checkOutput("hold_rdt", d, rdt_a[d] & held_mask[d], held_rdt[d] & held_mask[d]);
        checkOutput("hold_err", d, 32'(err_a[d]), 32'(held_err[d]));
      end
    end
  end

  always @(posedge rst) begin
    sbq.delete();
    for (int d = 0; d < ND; d++) begin
      held_rdt[d]  = '0;
      held_err[d]  = 1'b0;
      held_mask[d] = '1;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] adr;
    for (int d = 0; d < ND; d++) begin
      held_rdt[d]  = '0;
      held_err[d]  = 1'b0;
      held_mask[d] = '1;
      set_req(d, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    end
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("rst_rdy", 0, 32'(rdy_a[0]), 32'd1);
    checkOutput("rst_rdy", 1, 32'(rdy_a[1]), 32'd0);
    checkOutput("rst_rdy", 2, 32'(rdy_a[2]), 32'd1);
    checkOutput("rst_rdt", 2, rdt_a[2], 32'h0);
    #1 rst = 1'b0;
    @(negedge clk);

    $display("[TB] directed: WAIT=0 DLY=1");
    applyStimulus(0, 1'b1, 1'b0, 32'h10, 4'hF, 32'hDEADBEEF);
    applyStimulus(0, 1'b0, 1'b0, 32'h10, 4'h0, 32'h0);
    checkOutput("plan_wr_rd", 0, rdt_a[0], 32'hDEADBEEF);
    checkOutput("plan_err0", 0, 32'(err_a[0]), 32'd0);
    applyStimulus(0, 1'b1, 1'b0, 32'h20, 4'hF, 32'h11223344);
    applyStimulus(0, 1'b1, 1'b0, 32'h22, 4'b0101, 32'hAABBCCDD);
    applyStimulus(0, 1'b0, 1'b0, 32'h20, 4'h0, 32'h0);
    checkOutput("plan_ben", 0, rdt_a[0], 32'h11BB33DD);
    applyStimulus(0, 1'b1, 1'b1, 32'h30, 4'hF, 32'h01020304);
    applyStimulus(0, 1'b0, 1'b0, 32'h30, 4'h0, 32'h0);
    checkOutput("plan_big_le", 0, rdt_a[0], 32'h04030201);
    applyStimulus(0, 1'b0, 1'b1, 32'h30, 4'h0, 32'h0);
    checkOutput("plan_big_be", 0, rdt_a[0], 32'h01020304);
    applyStimulus(0, 1'b1, 1'b0, 32'h0, 4'hF, 32'h12345678);
    applyStimulus(0, 1'b1, 1'b0, 32'h1000, 4'hF, 32'hFFFFFFFF);
    checkOutput("plan_oor_wr_err", 0, 32'(err_a[0]), 32'd1);
    applyStimulus(0, 1'b0, 1'b0, 32'h1000, 4'h0, 32'h0);
    checkOutput("plan_oor_rd_err", 0, 32'(err_a[0]), 32'd1);
    checkOutput("plan_oor_rd_rdt", 0, rdt_a[0], 32'h0);
    applyStimulus(0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    checkOutput("plan_oor_nowr", 0, rdt_a[0], 32'h12345678);
    idle(0, 2);

    $display("[TB] directed: WAIT=3 DLY=3");
    applyStimulus(1, 1'b1, 1'b0, 32'h40, 4'hF, 32'hCAFEF00D);
    applyStimulus(1, 1'b0, 1'b0, 32'h40, 4'h0, 32'h0);
    idle(1, 2);
    checkOutput("plan_dly3", 1, rdt_a[1], 32'hCAFEF00D);
    idle(1, 2);

    $display("[TB] directed: WAIT=0 DLY=3 no error reporting");
    for (int i = 0; i < 8; i++) applyStimulus(2, 1'b1, 1'b0, 32'h100 + 32'(4*i), 4'hF, $urandom);
    for (int i = 0; i < 8; i++) applyStimulus(2, 1'b0, 1'b0, 32'h100 + 32'(4*i), 4'h0, 32'h0);
    idle(2, 4);
    applyStimulus(2, 1'b1, 1'b0, 32'h1000, 4'hF, 32'h5A5AA5A5);
    applyStimulus(2, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    idle(2, 3);
    checkOutput("plan_alias", 2, rdt_a[2], 32'h5A5AA5A5);
    checkOutput("plan_alias_err", 2, 32'(err_a[2]), 32'd0);

    $display("[TB] reset with reads in flight");
    applyStimulus(2, 1'b0, 1'b0, 32'h100, 4'h0, 32'h0);
    applyStimulus(2, 1'b0, 1'b0, 32'h104, 4'h0, 32'h0);
    #1 rst = 1'b1;
    set_req(2, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    repeat (5) @(negedge clk);
    checkOutput("post_rst_rdt", 2, rdt_a[2], 32'h0);
    checkOutput("post_rst_err", 2, 32'(err_a[2]), 32'd0);
    for (int i = 0; i < 8; i++) applyStimulus(2, 1'b0, 1'b0, 32'h100 + 32'(4*i), 4'h0, 32'h0);
    idle(2, 4);

    $display("[TB] random transfers");
    for (int d = 0; d < ND; d++) begin
      for (int n = 0; n < 150; n++) begin
        adr = 32'($urandom_range(0, 63));
        if ($urandom_range(0, 9) == 0) adr = adr + 32'h1000;
        applyStimulus(d, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), adr,
                      4'($urandom_range(0, 15)), $urandom);
        if ($urandom_range(0, 3) == 0) idle(d, $urandom_range(1, 3));
      end
      idle(d, 6);
    end

    for (int k = 0; k < 20 && sbq.size() > 0; k++) @(negedge clk);
    checkOutput("drain", 0, 32'(sbq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
